frame_capture_ctrl: RTL and testbench



---
 rtl/frame_capture_ctrl.sv | 154 +++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Sequences one camera frame capture: MCU request, exposure-settling frame skip,
// decimator run window, readout handshake, and abort on missing decimator completion.
module frame_capture_ctrl #(
  parameter int TIMEOUT_FRAMES = 3
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       req,
  input  logic       ack,
  input  logic [2:0] skip_cnt,
  input  logic       vsync,
  input  logic       dec_done,
  output logic       dec_reset,
  output logic       busy,
  output logic       frame_ready,
  output logic [7:0] frame_id,
  output logic       timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WAIT_VS = 3'd1;
  localparam logic [2:0] ST_CAPTURE = 3'd2;
  localparam logic [2:0] ST_READY   = 3'd3;
  localparam logic [2:0] ST_ERROR   = 3'd4;

  localparam logic [2:0] TO_LIMIT = TIMEOUT_FRAMES[2:0];

  logic       r_req_s1, r_req_s2, r_req_q;
  logic       r_ack_s1, r_ack_s2, r_ack_q;
  logic       r_vs_q;
  logic [2:0] r_state;
  logic [2:0] r_skip_left;
  logic [2:0] r_vs_cnt;

  logic       w_req_rise, w_ack_rise, w_vs_rise;
  logic [2:0] w_state_nxt;
  logic [2:0] w_skip_nxt;
  logic [2:0] w_vs_cnt_nxt;
  logic [2:0] w_vs_cnt_inc;
  logic       w_timeout_nxt;
  logic       w_frame_done;

  // req/ack come from MCU GPIOs; vsync is already in the pclk domain.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_req_s1 <= 1'b0;
      r_req_s2 <= 1'b0;
      r_req_q  <= 1'b0;
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
      r_ack_q  <= 1'b0;
      r_vs_q   <= 1'b0;
    end else begin
      r_req_s1 <= req;
      r_req_s2 <= r_req_s1;
      r_req_q  <= r_req_s2;
      r_ack_s1 <= ack;
      r_ack_s2 <= r_ack_s1;
      r_ack_q  <= r_ack_s2;
      r_vs_q   <= vsync;
    end
  end

  assign w_req_rise   = r_req_s2 & ~r_req_q;
  assign w_ack_rise   = r_ack_s2 & ~r_ack_q;
  assign w_vs_rise    = vsync & ~r_vs_q;
  assign w_vs_cnt_inc = r_vs_cnt + 3'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_skip_nxt   = r_skip_left;
    w_vs_cnt_nxt = r_vs_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_req_rise) begin
          w_state_nxt = ST_WAIT_VS;
          w_skip_nxt  = skip_cnt;
        end
      end
      ST_WAIT_VS: begin
        if (w_vs_rise) begin
          if (r_skip_left == 3'd0) begin
            w_state_nxt  = ST_CAPTURE;
            w_vs_cnt_nxt = 3'd0;
          end else begin
            w_skip_nxt = r_skip_left - 3'd1;
          end
        end
      end
      ST_CAPTURE: begin
        // A finished frame beats a timeout landing on the same edge.
        if (dec_done) begin
          w_state_nxt = ST_READY;
        end else if (w_vs_rise) begin
          w_vs_cnt_nxt = w_vs_cnt_inc;
          if (w_vs_cnt_inc == TO_LIMIT) begin
            w_state_nxt = ST_ERROR;
          end
        end
      end
      ST_READY: begin
        if (w_ack_rise) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERROR: begin
        if (w_req_rise) begin
          w_state_nxt = ST_WAIT_VS;
          w_skip_nxt  = skip_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_frame_done = (r_state == ST_CAPTURE) && (w_state_nxt == ST_READY);

  always_comb begin
    w_timeout_nxt = timeout;
    if ((r_state == ST_CAPTURE) && (w_state_nxt == ST_ERROR)) begin
      w_timeout_nxt = 1'b1;
    end else if ((r_state == ST_ERROR) && (w_state_nxt == ST_WAIT_VS)) begin
      w_timeout_nxt = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they move on the same edge as the FSM.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_skip_left <= 3'd0;
      r_vs_cnt    <= 3'd0;
      dec_reset   <= 1'b1;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      frame_id    <= 8'd0;
      timeout     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_skip_left <= w_skip_nxt;
      r_vs_cnt    <= w_vs_cnt_nxt;
      dec_reset   <= ~((w_state_nxt == ST_CAPTURE) || (w_state_nxt == ST_READY));
      busy        <= (w_state_nxt == ST_WAIT_VS) || (w_state_nxt == ST_CAPTURE);
      frame_ready <= (w_state_nxt == ST_READY);
      timeout     <= w_timeout_nxt;
      if (w_frame_done) begin
        frame_id <= frame_id + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed bench for frame_capture_ctrl: a cycle table for the basic capture,
// then hand sequences for skip, timeout, ignored req, async reset and frame_id wrap.
module tb_frame_capture_ctrl;

  logic       pclk;
  logic       reset;
  logic       req;
  logic       ack;
  logic [2:0] skip_cnt;
  logic       vsync;
  logic       dec_done;
  logic       dec_reset;
  logic       busy;
  logic       frame_ready;
  logic [7:0] frame_id;
  logic       timeout;

  int tests;
  int fails;
  logic [7:0] exp_fid;

  frame_capture_ctrl #(.TIMEOUT_FRAMES(3)) dut (
    .pclk        (pclk),
    .reset       (reset),
    .req         (req),
    .ack         (ack),
    .skip_cnt    (skip_cnt),
    .vsync       (vsync),
    .dec_done    (dec_done),
    .dec_reset   (dec_reset),
    .busy        (busy),
    .frame_ready (frame_ready),
    .frame_id    (frame_id),
    .timeout     (timeout)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  typedef struct {
    logic       req;
    logic       ack;
    logic       vs;
    logic       dd;
    logic       e_dr;
    logic       e_busy;
    logic       e_fr;
    logic       e_to;
    logic [7:0] e_fid;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string name, input logic dr, input logic b, input logic fr,
                         input logic to, input logic [7:0] fid);
    chk({name, ".dec_reset"}, {7'd0, dec_reset}, {7'd0, dr});
    chk({name, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({name, ".frame_ready"}, {7'd0, frame_ready}, {7'd0, fr});
    chk({name, ".timeout"}, {7'd0, timeout}, {7'd0, to});
    chk({name, ".frame_id"}, frame_id, fid);
  endtask

  // Apply inputs away from the edge, clock once, then sample just after the edge.
  task automatic step(input logic r, input logic a, input logic v, input logic d);
    @(negedge pclk);
    req      = r;
    ack      = a;
    vsync    = v;
    dec_done = d;
    @(posedge pclk);
    #1;
  endtask

  // req pulse: busy rises after the third edge counted from the first high sample.
  task automatic req_pulse();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic ack_pulse();
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic full_capture();
    req_pulse();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    exp_fid = exp_fid + 8'd1;
    ack_pulse();
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    exp_fid  = 8'd0;
    req      = 1'b0;
    ack      = 1'b0;
    vsync    = 1'b0;
    dec_done = 1'b0;
    skip_cnt = 3'd0;
    reset    = 1'b1;

    //            req ack vs dd  dr busy fr to fid
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1};
    tbl[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1};

    #12;
    chk_all("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge pclk);
    reset = 1'b0;

    // Basic capture; the long dec_done gap is covered by an idle stretch in CAPTURE.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].req, tbl[i].ack, tbl[i].vs, tbl[i].dd);
      chk_all($sformatf("basic[%0d]", i), tbl[i].e_dr, tbl[i].e_busy, tbl[i].e_fr,
              tbl[i].e_to, tbl[i].e_fid);
      if (i == 4) begin
        for (int k = 0; k < 1000; k++) step(0, 0, 1, 0);
        chk_all("basic_long_capture", 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
      end
    end
    exp_fid = 8'd1;

    // Skip two frames: dec_reset holds through two vsync rises, drops on the third.
    skip_cnt = 3'd2;
    req_pulse();
    chk_all("skip_busy", 1'b1, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 1, 0);
    chk_all("skip_vs1", 1'b1, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_all("skip_vs2", 1'b1, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_all("skip_vs3", 1'b0, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 0, 1);
    exp_fid = exp_fid + 8'd1;
    chk_all("skip_ready", 1'b0, 1'b0, 1'b1, 1'b0, exp_fid);
    ack_pulse();
    chk_all("skip_ack", 1'b1, 1'b0, 1'b0, 1'b0, exp_fid);
    skip_cnt = 3'd0;

    // Timeout: entry vsync plus three more rises without dec_done.
    req_pulse();
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_all("to_vs2", 1'b0, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk_all("to_abort", 1'b1, 1'b0, 1'b0, 1'b1, exp_fid);
    step(0, 0, 0, 0);
    ack_pulse();
    chk_all("to_ack_ignored", 1'b1, 1'b0, 1'b0, 1'b1, exp_fid);
    req_pulse();
    chk_all("to_rearm", 1'b1, 1'b1, 1'b0, 1'b0, exp_fid);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    exp_fid = exp_fid + 8'd1;
    chk_all("to_done_wins", 1'b0, 1'b0, 1'b1, 1'b0, exp_fid);
    step(0, 0, 0, 0);
    ack_pulse();

    // req while READY is dropped and must not start a capture after ack.
    req_pulse();
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    exp_fid = exp_fid + 8'd1;
    step(0, 0, 0, 0);
    req_pulse();
    chk_all("ready_req_ignored", 1'b0, 1'b0, 1'b1, 1'b0, exp_fid);
    ack_pulse();
    for (int k = 0; k < 5; k++) step(0, 0, (k % 2) == 0, 0);
    chk_all("no_second_capture", 1'b1, 1'b0, 1'b0, 1'b0, exp_fid);

    // Async reset mid-CAPTURE at frame_id 5.
    req_pulse();
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    exp_fid = exp_fid + 8'd1;
    step(0, 0, 0, 0);
    ack_pulse();
    req_pulse();
    step(0, 0, 1, 0);
    chk_all("pre_reset_capture", 1'b0, 1'b1, 1'b0, 1'b0, 8'd5);
    #1;
    reset = 1'b1;
    #1;
    chk_all("async_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    @(negedge pclk);
    reset = 1'b0;
    exp_fid = 8'd0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk_all("post_reset_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);

    // 256 capture/ack cycles wrap frame_id back to zero.
    for (int n = 0; n < 255; n++) full_capture();
    chk("wrap_255", frame_id, 8'd255);
    full_capture();
    chk("wrap_0", frame_id, exp_fid);
    chk("wrap_0_const", frame_id, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
